// File: rtl/branch_resolve_ctrl.sv
// Branch resolution sequencer between decode and the branch comparator.
// Holds decode while forwarded operands are pending, then redirects fetch on a taken branch.
module branch_resolve_ctrl #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             br_valid,
  output logic             br_ready,
  input  logic [2:0]       br_op,
  input  logic [WIDTH-1:0] br_target,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic             op1_pending,
  input  logic             op2_pending,
  input  logic             kill,
  output logic             stall_d,
  output logic             flush_f,
  output logic             pc_redirect,
  output logic [WIDTH-1:0] redirect_pc,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] resolved_cnt,
  output logic             err_timeout
);

  localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);
  localparam logic [WaitW-1:0] WaitLimit = WaitW'(MAX_WAIT);

  localparam logic [2:0] OpBeq  = 3'b001;
  localparam logic [2:0] OpBne  = 3'b100;
  localparam logic [2:0] OpBltz = 3'b110;

  typedef enum logic [1:0] {StIdle, StWait, StEval, StDone} state_e;

  state_e             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   target_q, target_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WaitW-1:0]   wait_cnt_q, wait_cnt_d;
  logic               taken_q, taken_d;
  logic               redirect_q, redirect_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   taken_cnt_q, taken_cnt_d;
  logic [CNT_W-1:0]   resolved_cnt_q, resolved_cnt_d;

  logic               operands_ready;
  logic [WaitW-1:0]   wait_cnt_inc;
  logic               eval_taken;

  assign operands_ready = ~op1_pending & ~op2_pending;
  assign wait_cnt_inc   = wait_cnt_q + WaitW'(1);

  // Comparator works only on latched operands; BLTZ looks at the sign of op1 alone.
  always_comb begin
    eval_taken = 1'b0;
    case (op_q)
      OpBeq:   eval_taken = (a_q == b_q);
      OpBne:   eval_taken = (a_q != b_q);
      OpBltz:  eval_taken = a_q[WIDTH-1];
      default: eval_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    target_d       = target_q;
    a_d            = a_q;
    b_d            = b_q;
    wait_cnt_d     = wait_cnt_q;
    taken_d        = taken_q;
    redirect_d     = 1'b0;
    err_d          = err_q;
    taken_cnt_d    = taken_cnt_q;
    resolved_cnt_d = resolved_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (br_valid && !kill) begin
          op_d     = br_op;
          target_d = br_target;
          taken_d  = 1'b0;
          if (operands_ready) begin
            a_d     = op1;
            b_d     = op2;
            state_d = StEval;
          end else begin
            wait_cnt_d = '0;
            state_d    = StWait;
          end
        end
      end
      StWait: begin
        if (kill) begin
          state_d = StIdle;
        end else begin
          wait_cnt_d = wait_cnt_inc;
          // Operands arriving on the timeout edge take priority over the error.
          if (operands_ready) begin
            a_d     = op1;
            b_d     = op2;
            state_d = StEval;
          end else if (wait_cnt_inc == WaitLimit) begin
            err_d   = 1'b1;
            taken_d = 1'b0;
            state_d = StDone;
          end
        end
      end
      StEval: begin
        if (kill) begin
          state_d = StIdle;
        end else begin
          taken_d    = eval_taken;
          redirect_d = eval_taken;
          state_d    = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
        if (!kill) begin
          if (resolved_cnt_q != '1) resolved_cnt_d = resolved_cnt_q + CNT_W'(1);
          if (taken_q && (taken_cnt_q != '1)) taken_cnt_d = taken_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      op_q           <= '0;
      target_q       <= '0;
      a_q            <= '0;
      b_q            <= '0;
      wait_cnt_q     <= '0;
      taken_q        <= 1'b0;
      redirect_q     <= 1'b0;
      err_q          <= 1'b0;
      taken_cnt_q    <= '0;
      resolved_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      target_q       <= target_d;
      a_q            <= a_d;
      b_q            <= b_d;
      wait_cnt_q     <= wait_cnt_d;
      taken_q        <= taken_d;
      redirect_q     <= redirect_d;
      err_q          <= err_d;
      taken_cnt_q    <= taken_cnt_d;
      resolved_cnt_q <= resolved_cnt_d;
    end
  end

  // redirect_q is only ever set for the DONE cycle; kill in DONE squashes it immediately.
  assign pc_redirect  = redirect_q & ~kill;
  assign flush_f      = redirect_q & ~kill;
  assign redirect_pc  = target_q;
  assign taken_cnt    = taken_cnt_q;
  assign resolved_cnt = resolved_cnt_q;
  assign err_timeout  = err_q;

  assign br_ready = (state_q == StIdle);
  assign stall_d  = ((state_q == StIdle) & br_valid) | (state_q == StWait) | (state_q == StEval);

endmodule
